// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package seq_div_pkg;

  localparam int unsigned SEQ_DIV_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Iteration counter width; N >= 2 keeps this at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in a quotient bit, trial-subtract, restore on borrow.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int unsigned N = SEQ_DIV_N
) (
  input  logic [N:0]   r_i,
  input  logic         q_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   r_nxt_c_o,
  output logic         q_bit_c_o
);

  logic [N:0]   trial;
  logic [N+1:0] diff;
  logic         unused_r_msb;

  // R[N] is zero for legal operands; it only exists to hold the pre-shift width.
  assign unused_r_msb = r_i[N];

  always_comb begin
    trial     = {r_i[N-1:0], q_msb_i};
    diff      = {1'b0, trial} - {2'b00, divisor_i};
    q_bit_c_o = ~diff[N+1];
    r_nxt_c_o = diff[N+1] ? trial : diff[N:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential 2N/N restoring divider with start/busy/done handshake, one quotient bit per clock.
// Optional SEQ_DIV_OVF_EN: detect quotient overflow (incl. divide-by-zero) at accept and finish in one cycle.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned N = SEQ_DIV_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [2*N-1:0] dividend_i,
  input  logic [N-1:0]   divisor_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [N-1:0]   quot_o,
  output logic [N-1:0]   rem_o,
  output logic           ovf_o
);

  localparam int unsigned      CW       = cnt_width(N);
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;

  logic [N:0]    step_r;
  logic          step_qbit;

`ifdef SEQ_DIV_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_pend_q, ovf_pend_d;
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  seq_div_step #(.N(N)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[N-1]),
    .divisor_i (dvs_q),
    .r_nxt_c_o (step_r),
    .q_bit_c_o (step_qbit)
  );

  // Next-state and result logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef SEQ_DIV_OVF_EN
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          r_d     = {1'b0, dividend_i[2*N-1:N]};
          q_d     = dividend_i[N-1:0];
          dvs_d   = divisor_i;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
`ifdef SEQ_DIV_OVF_EN
          ovf_pend_d = (dividend_i[2*N-1:N] >= divisor_i);
`endif
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = {q_q[N-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = {q_q[N-2:0], step_qbit};
          rem_d   = step_r[N-1:0];
`ifdef SEQ_DIV_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
`ifdef SEQ_DIV_OVF_EN
        // Overflow short-circuits the iterations: saturated quotient, zero remainder.
        if (ovf_pend_q) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          quot_d     = {N{1'b1}};
          rem_d      = '0;
          ovf_d      = 1'b1;
          ovf_pend_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef SEQ_DIV_OVF_EN
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef SEQ_DIV_OVF_EN
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (N=4); overflow cases build only with SEQ_DIV_OVF_EN.
module tb_seq_div;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quot;
  logic [3:0] rem;
  logic       ovf;

  int total;
  int bad;

  seq_div #(.N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .busy_o     (busy),
    .done_o     (done),
    .quot_o     (quot),
    .rem_o      (rem),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  // Launch one division from idle; returns at the negedge where done is seen (or after a timeout).
  task automatic do_div(input logic [7:0] dd, input logic [3:0] dv, output int lat,
                        output logic [3:0] q, output logic [3:0] r, output logic o);
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = quot; r = rem; o = ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, quot, rem, ovf} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b quot=%h rem=%h ovf=%b, want all 0",
               busy, done, quot, rem, ovf);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [3:0] q, r; logic o;
    do_div(8'h64, 4'd7, lat, q, r, o);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
    total++;
    if (q !== 4'd14 || r !== 4'd2 || o !== 1'b0) begin
      bad++; $display("FAIL basic_100_7: got q=%0d r=%0d ovf=%b want q=14 r=2 ovf=0", q, r, o);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_single_pulse: done got %b want 0", done); end
    total++;
    if (quot !== 4'd14 || rem !== 4'd2) begin
      bad++; $display("FAIL basic_hold: got q=%0d r=%0d want 14/2", quot, rem);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 8'd239; divisor = 4'd15;
    @(negedge clk);
    dividend = 8'd45; divisor = 4'd9;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_first: got %b want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4 || quot !== 4'd15 || rem !== 4'd14) begin
      bad++; $display("FAIL b2b_first_239_15: got lat=%0d q=%0d r=%0d want lat=4 q=15 r=14", lat, quot, rem);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_second_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    start = 1'b0;
    total++;
    if (lat !== 4 || quot !== 4'd5 || rem !== 4'd0) begin
      bad++; $display("FAIL b2b_second_45_9: got lat=%0d q=%0d r=%0d want lat=4 q=5 r=0", lat, quot, rem);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 8'h64; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd13;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4 || quot !== 4'd14 || rem !== 4'd2) begin
      bad++; $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d want lat=4 q=14 r=2", lat, quot, rem);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_start_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat; int seen; logic [3:0] q, r; logic o;
    @(negedge clk);
    start = 1'b1; dividend = 8'd239; divisor = 4'd15;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, done, quot, rem, ovf} !== 11'd0) begin
      bad++; $display("FAIL reset_mid_run: got busy=%b done=%b quot=%h rem=%h ovf=%b want all 0",
                      busy, done, quot, rem, ovf);
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", seen); end
    do_div(8'h64, 4'd7, lat, q, r, o);
    total++;
    if (lat !== 4 || q !== 4'd14 || r !== 4'd2) begin
      bad++; $display("FAIL reset_recover: got lat=%0d q=%0d r=%0d want lat=4 q=14 r=2", lat, q, r);
    end
  endtask

`ifdef SEQ_DIV_OVF_EN
  task automatic test_ovf();
    int lat; logic [3:0] q, r; logic o;
    do_div(8'h80, 4'd5, lat, q, r, o);
    total++;
    if (lat !== 1 || o !== 1'b1 || q !== 4'hF || r !== 4'h0) begin
      bad++; $display("FAIL ovf_80_5: got lat=%0d ovf=%b q=%h r=%h want lat=1 ovf=1 q=f r=0", lat, o, q, r);
    end
    do_div(8'h12, 4'd0, lat, q, r, o);
    total++;
    if (lat !== 1 || o !== 1'b1 || q !== 4'hF || r !== 4'h0) begin
      bad++; $display("FAIL ovf_div0: got lat=%0d ovf=%b q=%h r=%h want lat=1 ovf=1 q=f r=0", lat, o, q, r);
    end
    do_div(8'h64, 4'd7, lat, q, r, o);
    total++;
    if (o !== 1'b0 || q !== 4'd14) begin
      bad++; $display("FAIL ovf_clear: got ovf=%b q=%0d want ovf=0 q=14", o, q);
    end
  endtask
`endif

  task automatic test_exhaustive();
    int lat; logic [3:0] q, r; logic o;
    for (int dv = 1; dv < 16; dv++) begin
      for (int dd = 0; dd < 256; dd++) begin
        if ((dd >> 4) < dv) begin
          do_div(8'(dd), 4'(dv), lat, q, r, o);
          total++;
          if (lat !== 4 || (int'(q) * dv + int'(r)) !== dd || int'(r) >= dv || o !== 1'b0) begin
            bad++;
            $display("FAIL exhaustive %0d/%0d: got lat=%0d q=%0d r=%0d ovf=%b want lat=4 q=%0d r=%0d ovf=0",
                     dd, dv, lat, q, r, o, dd / dv, dd % dv);
          end
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
`ifdef SEQ_DIV_OVF_EN
    test_ovf();
`endif
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
